// File: rtl/stroke_plotter.sv
// stroke_plotter: walks a glyph table segment by segment and emits one Bresenham
// point per plot tick, with a done pulse after the terminal segment.
module stroke_plotter (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       step_tick,
  input  logic [7:0] start_x,
  input  logic [7:0] start_y,
  input  logic [7:0] end_x,
  input  logic [7:0] end_y,
  input  logic       pen_down,
  output logic [4:0] idx,
  output logic       enable,
  output logic [7:0] pos_x,
  output logic [7:0] pos_y,
  output logic       pen,
  output logic       point_valid,
  output logic       busy,
  output logic       done
);
  typedef enum logic [2:0] {IDLE, FETCH, SETUP, STEP, NEXT, FIN} state_t;
  state_t state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic [7:0] ex_q, ex_d, ey_q, ey_d, px_q, px_d, py_q, py_d;
  logic pen_q, pen_d, stx_q, stx_d, sty_q, sty_d, pv_q, pv_d;
  logic signed [9:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic signed [10:0] e2;
  logic [7:0] adx, ady;
  logic at_end, mx, my, last;
  always_comb begin
    e2 = {err_q, 1'b0};
    adx = ex_q > px_q ? ex_q - px_q : px_q - ex_q;
    ady = ey_q > py_q ? ey_q - py_q : py_q - ey_q;
    at_end = px_q == ex_q && py_q == ey_q;
    mx = e2 >= dy_q;
    my = e2 <= dx_q;
    last = idx_q == 5'd31 || (idx_q != 5'd0 && ex_q == 8'd0 && ey_q == 8'd0 && !pen_q);
    state_d = state_q;
    idx_d = idx_q;
    ex_d = ex_q;
    ey_d = ey_q;
    px_d = px_q;
    py_d = py_q;
    pen_d = pen_q;
    stx_d = stx_q;
    sty_d = sty_q;
    dx_d = dx_q;
    dy_d = dy_q;
    err_d = err_q;
    pv_d = 1'b0;
    case (state_q)
      IDLE: state_d = start ? FETCH : IDLE;
      FETCH: begin
        ex_d = end_x;
        ey_d = end_y;
        px_d = start_x;
        py_d = start_y;
        pen_d = pen_down;
        state_d = SETUP;
      end
      SETUP: begin
        dx_d = $signed({2'b00, adx});
        dy_d = -$signed({2'b00, ady});
        err_d = $signed({2'b00, adx}) - $signed({2'b00, ady});
        stx_d = ex_q > px_q;
        sty_d = ey_q > py_q;
        state_d = STEP;
      end
      STEP: if (step_tick) begin
        if (at_end) state_d = NEXT;
        else begin
          err_d = err_q + (mx ? dy_q : 10'sd0) + (my ? dx_q : 10'sd0);
          px_d = mx ? (stx_q ? px_q + 8'd1 : px_q - 8'd1) : px_q;
          py_d = my ? (sty_q ? py_q + 8'd1 : py_q - 8'd1) : py_q;
          pv_d = 1'b1;
        end
      end
      NEXT: begin
        state_d = last ? FIN : FETCH;
        idx_d = last ? idx_q : idx_q + 5'd1;
      end
      FIN: begin
        state_d = IDLE;
        idx_d = 5'd0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      ex_q <= '0;
      ey_q <= '0;
      px_q <= '0;
      py_q <= '0;
      pen_q <= 1'b0;
      stx_q <= 1'b0;
      sty_q <= 1'b0;
      dx_q <= '0;
      dy_q <= '0;
      err_q <= '0;
      pv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      ex_q <= ex_d;
      ey_q <= ey_d;
      px_q <= px_d;
      py_q <= py_d;
      pen_q <= pen_d;
      stx_q <= stx_d;
      sty_q <= sty_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
      err_q <= err_d;
      pv_q <= pv_d;
    end
  end
  assign idx = idx_q;
  assign enable = state_q inside {FETCH, SETUP, STEP, NEXT};
  assign busy = enable;
  assign done = state_q == FIN;
  assign pos_x = px_q;
  assign pos_y = py_q;
  assign pen = pen_q;
  assign point_valid = pv_q;
endmodule

// File: tb/tb_stroke_plotter.sv
// tb_stroke_plotter: table vectors, corner sequences and random glyphs against a
// point-list model of the line walker.
module tb_stroke_plotter;
  logic clk = 0, rst = 0, start = 0, step_tick = 0, pen_down;
  logic [7:0] start_x, start_y, end_x, end_y, pos_x, pos_y;
  logic [4:0] idx;
  logic enable, pen, point_valid, busy, done;
  logic [7:0] tsx[32], tsy[32], tex[32], tey[32];
  logic tpd[32];
  typedef struct packed {logic [7:0] x; logic [7:0] y; logic p;} pt_t;
  typedef struct {int sx, sy, ex, ey; bit pd; int n;} vec_t;
  pt_t got_q[$], exp_q[$], ref_q[$];
  int cyc_q[$];
  int tests = 0, fails = 0, cyc = 0, period = 1;
  int done_cnt, t1, t2, idx1_pulses, max_idx;
  vec_t vecs[8];

  stroke_plotter dut (
    .clk(clk), .rst(rst), .start(start), .step_tick(step_tick),
    .start_x(start_x), .start_y(start_y), .end_x(end_x), .end_y(end_y),
    .pen_down(pen_down), .idx(idx), .enable(enable), .pos_x(pos_x),
    .pos_y(pos_y), .pen(pen), .point_valid(point_valid), .busy(busy), .done(done)
  );

  assign start_x = tsx[idx];
  assign start_y = tsy[idx];
  assign end_x = tex[idx];
  assign end_y = tey[idx];
  assign pen_down = tpd[idx];

  always #5 clk = ~clk;

  initial begin
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      step_tick = period == 0 ? 1'($urandom_range(1)) : (n % period == 0);
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (point_valid) begin
      got_q.push_back('{pos_x, pos_y, pen});
      cyc_q.push_back(cyc);
      if (idx == 5'd1) idx1_pulses++;
    end
    if (done) done_cnt++;
    if (idx == 5'd1 && t1 < 0) t1 = cyc;
    if (idx == 5'd2 && t2 < 0) t2 = cyc;
    if (int'(idx) > max_idx) max_idx = int'(idx);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic clear_table();
    for (int i = 0; i < 32; i++) begin
      tsx[i] = 0; tsy[i] = 0; tex[i] = 0; tey[i] = 0; tpd[i] = 0;
    end
  endtask

  task automatic set_seg(input int i, input int sx, input int sy, input int ex, input int ey, input bit pd);
    tsx[i] = 8'(sx); tsy[i] = 8'(sy); tex[i] = 8'(ex); tey[i] = 8'(ey); tpd[i] = pd;
  endtask

  // Expected point list for the whole glyph, plus how many segments get visited.
  task automatic model(output int nseg);
    exp_q.delete();
    nseg = 0;
    for (int i = 0; i < 32; i++) begin
      int x, y, ex, ey, dx, dy, err, e2, s1, s2;
      x = tsx[i]; y = tsy[i]; ex = tex[i]; ey = tey[i];
      dx = ex > x ? ex - x : x - ex;
      dy = -(ey > y ? ey - y : y - ey);
      err = dx + dy;
      s1 = ex > x ? 1 : -1;
      s2 = ey > y ? 1 : -1;
      while (!(x == ex && y == ey)) begin
        e2 = 2 * err;
        if (e2 >= dy) begin err += dy; x += s1; end
        if (e2 <= dx) begin err += dx; y += s2; end
        exp_q.push_back('{x[7:0], y[7:0], tpd[i]});
      end
      nseg = i + 1;
      if (i == 31 || (i != 0 && ex == 0 && ey == 0 && !tpd[i])) break;
    end
  endtask

  task automatic run_glyph(input int per, input int poke, input string nm);
    int nseg, k, bad, first, m;
    model(nseg);
    period = per;
    got_q.delete(); cyc_q.delete();
    done_cnt = 0; t1 = -1; t2 = -1; idx1_pulses = 0; max_idx = 0;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    for (k = 0; k < 40000 && !done; k++) begin
      @(negedge clk);
      start = poke == 1 && k == 40;
    end
    chk({nm, " done seen"}, done, 1);
    if (poke == 2) start = 1;
    @(negedge clk); start = 0;
    repeat (3) @(negedge clk);
    chk({nm, " pulse count"}, got_q.size(), exp_q.size());
    m = got_q.size() < exp_q.size() ? got_q.size() : exp_q.size();
    bad = 0; first = -1;
    for (int i = 0; i < m; i++) if (got_q[i] !== exp_q[i]) begin
      bad++;
      if (first < 0) first = i;
    end
    chk({nm, " points differing"}, bad, 0);
    if (first >= 0) $display("  %s first diff at %0d: got %h want %h", nm, first, got_q[first], exp_q[first]);
    chk({nm, " done pulses"}, done_cnt, 1);
    chk({nm, " idx after"}, idx, 0);
    chk({nm, " busy after"}, busy, 0);
    chk({nm, " final pos"}, {pos_x, pos_y}, {tex[nseg-1], tey[nseg-1]});
    chk({nm, " final pen"}, pen, tpd[nseg-1]);
    chk({nm, " last idx"}, max_idx, nseg - 1);
  endtask

  initial begin
    int bad, bad2, cr, x, y, nb, px, py, n;
    vecs[0] = '{0, 0, 60, 120, 1'b0, 120};
    vecs[1] = '{60, 120, 60, 40, 1'b1, 80};
    vecs[2] = '{60, 40, 180, 40, 1'b1, 120};
    vecs[3] = '{180, 40, 0, 0, 1'b0, 180};
    vecs[4] = '{255, 255, 0, 0, 1'b1, 255};
    vecs[5] = '{0, 255, 255, 0, 1'b0, 255};
    vecs[6] = '{10, 10, 13, 20, 1'b1, 10};
    vecs[7] = '{5, 5, 5, 5, 1'b1, 0};
    clear_table();
    #1 rst = 1;
    #1 chk("reset outputs", {idx, enable, pos_x, pos_y, pen, point_valid, busy, done}, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
    chk("idle without start", {busy, done, point_valid}, 0);

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      clear_table();
      set_seg(0, v.sx, v.sy, v.ex, v.ey, v.pd);
      set_seg(1, v.ex, v.ey, 0, 0, 0);
      run_glyph(i % 3 + 1, 0, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d total pulses", i), got_q.size(), v.n + (v.ex > v.ey ? v.ex : v.ey));
      bad = 0; bad2 = 0;
      for (int j = 0; j < v.n && j < got_q.size(); j++) begin
        x = int'(got_q[j].x); y = int'(got_q[j].y);
        cr = (x - v.sx) * (v.ey - v.sy) - (y - v.sy) * (v.ex - v.sx);
        if (cr < 0) cr = -cr;
        if (cr > v.n) bad++;
        if (got_q[j].p != v.pd) bad2++;
      end
      chk($sformatf("vec%0d off-line points", i), bad, 0);
      chk($sformatf("vec%0d pen mismatches", i), bad2, 0);
      if (v.n > 0 && got_q.size() >= v.n)
        chk($sformatf("vec%0d segment end", i), {got_q[v.n-1].x, got_q[v.n-1].y}, {8'(v.ex), 8'(v.ey)});
    end

    clear_table();
    set_seg(0, 0, 0, 60, 120, 0);
    set_seg(1, 60, 120, 60, 40, 1);
    set_seg(2, 60, 40, 180, 40, 1);
    set_seg(3, 180, 40, 0, 0, 0);
    run_glyph(1, 0, "table p1");
    chk("table p1 total", got_q.size(), 500);
    ref_q = got_q;
    run_glyph(4, 0, "table p4");
    bad = 0;
    for (int i = 0; i < got_q.size() && i < ref_q.size(); i++) if (got_q[i] !== ref_q[i]) bad++;
    chk("p4 vs p1 sequence", bad, 0);
    bad = 0;
    for (int i = 1; i < 120 && i < cyc_q.size(); i++) if (cyc_q[i] - cyc_q[i-1] != 4) bad++;
    chk("p4 pulse spacing", bad, 0);

    clear_table();
    set_seg(0, 0, 0, 100, 100, 1);
    set_seg(1, 100, 100, 100, 100, 1);
    set_seg(2, 100, 100, 0, 0, 0);
    run_glyph(1, 2, "zero-len");
    chk("zero-len idx1 to idx2 cycles", t2 - t1, 4);
    chk("zero-len pulses at idx1", idx1_pulses, 0);

    clear_table();
    set_seg(0, 0, 0, 60, 120, 0);
    set_seg(1, 60, 120, 60, 40, 1);
    set_seg(2, 60, 40, 180, 40, 1);
    set_seg(3, 180, 40, 0, 0, 0);
    period = 1;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    n = 0;
    while (n < 2000 && !(pos_x == 8'd60 && pos_y == 8'd80 && busy)) begin
      @(negedge clk);
      n++;
    end
    chk("reached (60,80)", n < 2000, 1);
    #2 rst = 1;
    #1 chk("async reset outputs", {idx, enable, pos_x, pos_y, pen, point_valid, busy, done}, 0);
    @(negedge clk); rst = 0;
    repeat (3) @(negedge clk);
    chk("post-reset idle", {busy, idx, point_valid, pos_x, pos_y}, 0);
    run_glyph(1, 1, "replay");

    clear_table();
    px = 0; py = 0;
    for (int i = 0; i < 32; i++) begin
      x = $urandom_range(1, 40); y = $urandom_range(1, 40);
      set_seg(i, px, py, x, y, 1);
      px = x; py = y;
    end
    run_glyph(2, 0, "no terminal");
    chk("no terminal max idx", max_idx, 31);

    for (int g = 0; g < 6; g++) begin
      clear_table();
      nb = $urandom_range(1, 4);
      px = $urandom_range(0, 255); py = $urandom_range(0, 255);
      for (int i = 0; i < nb; i++) begin
        x = $urandom_range(0, 255); y = $urandom_range(0, 255);
        set_seg(i, px, py, x, y, 1'($urandom_range(1)));
        px = x; py = y;
      end
      set_seg(nb, px, py, 0, 0, 0);
      run_glyph(0, 0, $sformatf("rand%0d", g));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
